// File: rtl/weight_buf_loader.sv
// weight_buf_loader: packs IN_W-bit AXI-Stream beats into WIDTH-bit words and writes them to the weight buffer.
// Defining LOADER_CSUM_EN adds the csum port and a running checksum of the written words.
module weight_buf_loader #(
  parameter int BUF_ADDR_W = 16,
  parameter int WIDTH      = 128,
  parameter int IN_W       = 32
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BUF_ADDR_W-1:0] base_addr,
  input  logic [BUF_ADDR_W:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  err_last,
  input  logic [IN_W-1:0]       s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic                  dma_wr_en,
  output logic [BUF_ADDR_W-1:0] dma_wr_addr,
  output logic [WIDTH-1:0]      dma_wr_data
`ifdef LOADER_CSUM_EN
  ,
  output logic [31:0]           csum
`endif
);

  localparam int BEATS  = WIDTH / IN_W;
  localparam int LANE_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NW_W   = BUF_ADDR_W + 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [BUF_ADDR_W-1:0]   base_q;
  logic [NW_W-1:0]         nwords_q;
  logic [NW_W-1:0]         word_idx;
  logic [LANE_W-1:0]       lane;
  logic [WIDTH-1:0]        pack;
  logic [WIDTH-1:0]        word_nxt;
  logic                    cmd_acc;
  logic                    beat_ok;
  logic                    final_beat;
  logic                    wr_req;
  logic                    err_set;

  assign busy          = (state == S_LOAD) || (state == S_FLUSH);
  assign done          = (state == S_DONE);
  assign s_axis_tready = (state == S_LOAD);
  assign cmd_acc       = (state == S_IDLE) && start;

  always_comb begin
    state_nxt  = state;
    beat_ok    = 1'b0;
    final_beat = 1'b0;
    wr_req     = 1'b0;
    err_set    = 1'b0;
    word_nxt   = pack;
    // pack is zero above the current lane, so an early tlast leaves unfilled lanes at zero
    for (int k = 0; k < BEATS; k++) begin
      if (LANE_W'(k) == lane) word_nxt[k*IN_W +: IN_W] = s_axis_tdata;
    end
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (num_words == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (s_axis_tvalid) begin
          beat_ok    = 1'b1;
          final_beat = (lane == LAST_LANE) && (word_idx == nwords_q - NW_W'(1));
          wr_req     = (lane == LAST_LANE) || s_axis_tlast;
          err_set    = s_axis_tlast != final_beat;
          if (final_beat || s_axis_tlast) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state       <= S_IDLE;
      base_q      <= '0;
      nwords_q    <= '0;
      word_idx    <= '0;
      lane        <= '0;
      pack        <= '0;
      err_last    <= 1'b0;
      dma_wr_en   <= 1'b0;
      dma_wr_addr <= '0;
      dma_wr_data <= '0;
    end else begin
      state     <= state_nxt;
      dma_wr_en <= wr_req;
      if (cmd_acc) begin
        base_q   <= base_addr;
        nwords_q <= num_words;
        word_idx <= '0;
        lane     <= '0;
        pack     <= '0;
        err_last <= 1'b0;
      end
      if (beat_ok) begin
        if (wr_req) begin
          lane        <= '0;
          pack        <= '0;
          word_idx    <= word_idx + NW_W'(1);
          // address arithmetic wraps naturally at BUF_ADDR_W bits
          dma_wr_addr <= base_q + word_idx[BUF_ADDR_W-1:0];
          dma_wr_data <= word_nxt;
        end else begin
          lane <= lane + LANE_W'(1);
          pack <= word_nxt;
        end
        if (err_set) err_last <= 1'b1;
      end
    end
  end

`ifdef LOADER_CSUM_EN
  function automatic logic [31:0] slice_sum(input logic [WIDTH-1:0] w);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < WIDTH / 32; i++) s = s + w[i*32 +: 32];
    return s;
  endfunction

  // updated on the same edge that raises dma_wr_en for the word
  always_ff @(posedge clka) begin
    if (rst)          csum <= '0;
    else if (cmd_acc) csum <= '0;
    else if (wr_req)  csum <= csum + slice_sum(word_nxt);
  end
`endif

endmodule

// File: tb/tb_weight_buf_loader.sv
// Self-checking bench for weight_buf_loader: scoreboard of expected buffer writes plus per-scenario checks.
module tb_weight_buf_loader;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   base_addr = '0;
  logic [16:0]   num_words = '0;
  logic          busy, done, err_last;
  logic [31:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          dma_wr_en;
  logic [15:0]   dma_wr_addr;
  logic [127:0]  dma_wr_data;
`ifdef LOADER_CSUM_EN
  logic [31:0]   csum;
`endif

  weight_buf_loader #(.BUF_ADDR_W(16), .WIDTH(128), .IN_W(32)) dut (
    .clka(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .err_last(err_last),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr), .dma_wr_data(dma_wr_data)
`ifdef LOADER_CSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] data;
  } exp_t;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          wr_count = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  exp_t        exp_q[$];
  int          wr_cyc_q[$];
  int          acc_q[$];
  logic [31:0] bq[$];
  logic [31:0] exp_csum;

  always @(posedge clk) cyc <= cyc + 1;

  // write monitor: every write is popped against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (dma_wr_en) begin
      wr_count++;
      wr_cyc_q.push_back(cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write addr=%h data=%h", dma_wr_addr, dma_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (dma_wr_addr !== e.addr || dma_wr_data !== e.data) begin
          miscompares++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   dma_wr_addr, dma_wr_data, e.addr, e.data);
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic issue(input logic [15:0] base, input logic [16:0] n, output int start_edge);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_words = n;
    @(negedge clk);
    start_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input bit gap, output int edge_no);
    int n;
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        s_axis_tvalid = 1'b0;
        start = $urandom_range(0, 1);
        base_addr = 16'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = last;
    n = 0; edge_no = -1;
    while (edge_no < 0) begin
      @(negedge clk);
      if (s_axis_tready) begin
        edge_no = cyc + 1;
        @(posedge clk); #1;
      end else begin
        n++;
        if (n > 50) begin
          vectors++; miscompares++;
          $display("FAIL tready_timeout got 0 want 1");
          edge_no = 0;
        end
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++;
    if (done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL done_pulse got %0d pulses want 1", done_cnt - d0);
    end
  endtask

  // builds the expected writes from bq, then runs one command beat by beat
  task automatic run_cmd(input logic [15:0] base, input logic [16:0] n, input int last_at, input bit gap);
    int   d0, e, se;
    exp_t x;
    wr_cyc_q.delete(); acc_q.delete(); exp_csum = '0;
    for (int w = 0; w * 4 < bq.size(); w++) begin
      x.addr = base + 16'(w);
      x.data = '0;
      for (int l = 0; l < 4; l++)
        if (w * 4 + l < bq.size()) x.data[l*32 +: 32] = bq[w*4 + l];
      for (int l = 0; l < 4; l++) exp_csum += x.data[l*32 +: 32];
      exp_q.push_back(x);
    end
    d0 = done_cnt;
    issue(base, n, se);
    for (int i = 0; i < bq.size(); i++) begin
      send(bq[i], i == last_at, gap, e);
      acc_q.push_back(e);
    end
    wait_done(d0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors += 7;
    if (busy !== 1'b0)          begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0)          begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
    if (err_last !== 1'b0)      begin miscompares++; $display("FAIL rst_err got %b want 0", err_last); end
    if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL rst_tready got %b want 0", s_axis_tready); end
    if (dma_wr_en !== 1'b0)     begin miscompares++; $display("FAIL rst_wr_en got %b want 0", dma_wr_en); end
    if (dma_wr_addr !== 16'h0)  begin miscompares++; $display("FAIL rst_addr got %h want 0", dma_wr_addr); end
    if (dma_wr_data !== '0)     begin miscompares++; $display("FAIL rst_data got %h want 0", dma_wr_data); end
  endtask

  task automatic test_reset_mid_load();
    int e, w0, d0, bad;
    w0 = wr_count; d0 = done_cnt; bad = 0;
    issue(16'h0020, 17'd1, e);
    send(32'hAAAA0001, 1'b0, 1'b0, e);
    send(32'hAAAA0002, 1'b0, 1'b0, e);
    rst = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'hAAAA0003;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      if (dma_wr_en !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 1'b0) bad++;
    end
    #1 rst = 1'b0; s_axis_tvalid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    vectors += 3;
    if (bad != 0) begin miscompares++; $display("FAIL rst_mid_outputs got %0d bad cycles want 0", bad); end
    if (wr_count != w0) begin miscompares++; $display("FAIL rst_mid_write got %0d writes want 0", wr_count - w0); end
    if (done_cnt != d0) begin miscompares++; $display("FAIL rst_mid_done got %0d pulses want 0", done_cnt - d0); end
    bq = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    run_cmd(16'h0030, 17'd1, 3, 1'b0);
  endtask

  task automatic test_basic();
    bq = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    run_cmd(16'h0010, 17'd2, 7, 1'b0);
    vectors += 4;
    if (wr_cyc_q.size() != 2) begin
      miscompares += 3;
      $display("FAIL basic_write_count got %0d want 2", wr_cyc_q.size());
    end else begin
      if (wr_cyc_q[0] != acc_q[3]) begin miscompares++; $display("FAIL basic_wr0_cycle got %0d want %0d", wr_cyc_q[0], acc_q[3]); end
      if (wr_cyc_q[1] != acc_q[7]) begin miscompares++; $display("FAIL basic_wr1_cycle got %0d want %0d", wr_cyc_q[1], acc_q[7]); end
      if (done_cyc != acc_q[7] + 1) begin miscompares++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, acc_q[7] + 1); end
    end
    if (err_last !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b want 0", err_last); end
  endtask

  task automatic test_missing_tlast();
    int w0, tr;
    bq = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
    run_cmd(16'h0100, 17'd1, -1, 1'b0);
    vectors++;
    if (err_last !== 1'b1) begin miscompares++; $display("FAIL missing_tlast_err got %b want 1", err_last); end
    w0 = wr_count; tr = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEADBEEF;
    repeat (4) begin @(negedge clk); if (s_axis_tready) tr++; end
    #1 s_axis_tvalid = 1'b0;
    vectors += 2;
    if (tr != 0) begin miscompares++; $display("FAIL extra_beat_tready got %0d cycles want 0", tr); end
    if (wr_count != w0) begin miscompares++; $display("FAIL extra_beat_write got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_wrap();
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back($urandom);
    run_cmd(16'hFFFF, 17'd2, 7, 1'b0);
    vectors++;
    if (err_last !== 1'b0) begin miscompares++; $display("FAIL wrap_err_cleared got %b want 0", err_last); end
  endtask

  task automatic test_zero_words();
    int e, d0, w0, tr;
    d0 = done_cnt; w0 = wr_count; tr = 0;
    issue(16'h0070, 17'd0, e);
    repeat (4) begin @(negedge clk); if (s_axis_tready) tr++; end
    #1;
    vectors += 4;
    if (tr != 0) begin miscompares++; $display("FAIL zero_tready got %0d cycles want 0", tr); end
    if (done_cnt != d0 + 1) begin miscompares++; $display("FAIL zero_done got %0d pulses want 1", done_cnt - d0); end
    if (done_cyc > e + 1) begin miscompares++; $display("FAIL zero_done_cycle got %0d want <= %0d", done_cyc, e + 1); end
    if (wr_count != w0) begin miscompares++; $display("FAIL zero_write got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_early_tlast();
    int tr;
    bq = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    run_cmd(16'h0040, 17'd2, 5, 1'b0);
    vectors++;
    if (err_last !== 1'b1) begin miscompares++; $display("FAIL early_tlast_err got %b want 1", err_last); end
    tr = 0;
    s_axis_tvalid = 1'b1;
    repeat (3) begin @(negedge clk); if (s_axis_tready) tr++; end
    #1 s_axis_tvalid = 1'b0;
    vectors++;
    if (tr != 0) begin miscompares++; $display("FAIL early_tlast_tready got %0d cycles want 0", tr); end
  endtask

  task automatic test_back_to_back_gaps();
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back($urandom);
    run_cmd(16'h0200, 17'd3, 11, 1'b1);
    vectors++;
    if (err_last !== 1'b0) begin miscompares++; $display("FAIL gaps_err got %b want 0", err_last); end
  endtask

`ifdef LOADER_CSUM_EN
  task automatic test_csum();
    logic [31:0] c1;
    bq = '{32'h4, 32'h3, 32'h2, 32'h1};
    run_cmd(16'h0050, 17'd1, 3, 1'b0);
    vectors++;
    if (csum !== 32'h0000000A) begin miscompares++; $display("FAIL csum_one_word got %h want 0000000a", csum); end
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back($urandom);
    run_cmd(16'h0060, 17'd2, 7, 1'b0);
    c1 = csum;
    vectors++;
    if (c1 !== exp_csum) begin miscompares++; $display("FAIL csum_gapless got %h want %h", c1, exp_csum); end
    run_cmd(16'h0060, 17'd2, 7, 1'b1);
    vectors++;
    if (csum !== exp_csum) begin miscompares++; $display("FAIL csum_gaps got %h want %h", csum, exp_csum); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_load();
    test_basic();
    test_missing_tlast();
    test_wrap();
    test_zero_words();
    test_early_tlast();
    test_back_to_back_gaps();
`ifdef LOADER_CSUM_EN
    test_csum();
`endif
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
